// File: rtl/counter_10000_ctrl.sv
// Debounced run/stop, clear and mode buttons controlling a 0..9999 decimal counter
// that steps once every TICK_DIV clocks while running.
module counter_10000_ctrl #(
   parameter int TICK_DIV = 10_000_000,
   parameter int DB_LEN   = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_run_stop,
   input  logic        btn_clear,
   input  logic        btn_mode,
   output logic [13:0] counter,
   output logic        running,
   output logic        mode_down,
   output logic        tick
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DBC_W = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
   localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DB_LEN - 1);
   localparam logic [13:0]      CNT_MAX = 14'd9999;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   logic [2:0] btn_raw;
   logic [2:0] press;

   assign btn_raw = {btn_mode, btn_clear, btn_run_stop};

   // Bit 0 = run/stop, bit 1 = clear, bit 2 = mode.
   for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             db_lvl_q;
      logic             db_lvl_d;
      logic             db_lvl_dly_q;
      logic [DBC_W-1:0] db_cnt_q;
      logic [DBC_W-1:0] db_cnt_d;

      always_comb begin
         db_cnt_d = '0;
         db_lvl_d = db_lvl_q;
         if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DBC_MAX) begin
               db_lvl_d = sync2_q;
            end else begin
               db_cnt_d = db_cnt_q + DBC_W'(1);
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_lvl_q     <= 1'b0;
            db_lvl_dly_q <= 1'b0;
            db_cnt_q     <= '0;
         end else begin
            sync1_q      <= btn_raw[gi];
            sync2_q      <= sync1_q;
            db_lvl_q     <= db_lvl_d;
            db_lvl_dly_q <= db_lvl_q;
            db_cnt_q     <= db_cnt_d;
         end
      end

      assign press[gi] = db_lvl_q & ~db_lvl_dly_q;
   end

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [13:0]      counter_q, counter_d;
   logic             mode_down_q, mode_down_d;
   logic             running_q, running_d;
   logic             tick_w;
   logic [13:0]      step_val;

   assign tick_w = (state_q == ST_RUN) && (div_q == DIV_MAX);

   always_comb begin
      step_val = '0;
      if (counter_q > CNT_MAX) begin
         step_val = '0;
      end else if (mode_down_q) begin
         step_val = (counter_q == 14'd0) ? CNT_MAX : counter_q - 14'd1;
      end else begin
         step_val = (counter_q == CNT_MAX) ? 14'd0 : counter_q + 14'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      counter_d   = counter_q;
      mode_down_d = mode_down_q;
      case (state_q)
         ST_STOP: begin
            if (press[1]) begin
               state_d = ST_CLEAR;
            end else if (press[0]) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            div_d = tick_w ? '0 : div_q + DIV_W'(1);
            if (tick_w) begin
               counter_d = step_val;
            end
            if (press[0]) begin
               state_d = ST_STOP;
            end
         end
         ST_CLEAR: begin
            counter_d = '0;
            div_d     = '0;
            state_d   = ST_STOP;
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase
      if (press[2]) begin
         mode_down_d = ~mode_down_q;
      end
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_STOP;
         div_q       <= '0;
         counter_q   <= '0;
         mode_down_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         counter_q   <= counter_d;
         mode_down_q <= mode_down_d;
         running_q   <= running_d;
      end
   end

   assign counter   = counter_q;
   assign running   = running_q;
   assign mode_down = mode_down_q;
   assign tick      = tick_w;

endmodule

// File: tb/tb_counter_10000_ctrl.sv
// Directed bench for counter_10000_ctrl with TICK_DIV=5, DB_LEN=4; inputs change
// and outputs are sampled on the falling edge.
module tb_counter_10000_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  btn = 3'b000;
   logic [13:0] counter;
   logic        running;
   logic        mode_down;
   logic        tick;

   int checks   = 0;
   int failures = 0;
   int tick_cnt = 0;
   int tick_mark;

   counter_10000_ctrl #(
      .TICK_DIV(5),
      .DB_LEN  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_run_stop(btn[0]),
      .btn_clear   (btn[1]),
      .btn_mode    (btn[2]),
      .counter     (counter),
      .running     (running),
      .mode_down   (mode_down),
      .tick        (tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tick) tick_cnt <= tick_cnt + 1;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Raise the selected buttons, hold until the state has reacted, then release.
   task automatic pulse_btns(input logic [2:0] m);
      btn = btn | m;
      cycles(7);
      btn = btn & ~m;
   endtask

   initial begin
      cycles(2);
      check_val("rst_counter", counter, 0);
      check_val("rst_running", running, 0);
      check_val("rst_mode", mode_down, 0);
      check_val("rst_tick", tick, 0);
      rst = 1'b0;
      cycles(2);

      // Start running; first step lands TICK_DIV edges after entry.
      btn[0] = 1'b1;
      cycles(6);
      check_val("run_not_yet", running, 0);
      cycles(1);
      check_val("run_entry", running, 1);
      cycles(3);
      btn[0] = 1'b0;
      check_val("tick_before", tick, 0);
      cycles(1);
      check_val("first_tick", tick, 1);
      check_val("cnt_before_step", counter, 0);
      cycles(1);
      check_val("first_step", counter, 1);
      check_val("tick_after", tick, 0);
      cycles(55);
      check_val("cnt_60", counter, 12);

      // Stop lands with div=2; counter holds while stopped.
      pulse_btns(3'b001);
      check_val("stop_running", running, 0);
      check_val("stop_cnt", counter, 13);
      tick_mark = tick_cnt;
      cycles(50);
      check_val("idle_cnt", counter, 13);
      check_val("idle_ticks", tick_cnt - tick_mark, 0);

      // Resume mid-period: tick two cycles after re-entry.
      pulse_btns(3'b001);
      check_val("resume_running", running, 1);
      check_val("resume_tick0", tick, 0);
      cycles(1);
      check_val("resume_tick1", tick, 0);
      cycles(1);
      check_val("resume_tick2", tick, 1);
      check_val("resume_cnt", counter, 13);
      cycles(1);
      check_val("resume_step", counter, 14);

      // Clear while running is ignored.
      pulse_btns(3'b010);
      cycles(3);
      check_val("clr_run_cnt", counter, 16);
      check_val("clr_run_running", running, 1);

      // Stop at counter=37 with div=3, then clear.
      cycles(101);
      pulse_btns(3'b001);
      check_val("stop37_running", running, 0);
      check_val("stop37_cnt", counter, 37);
      pulse_btns(3'b010);
      check_val("clear_state_cnt", counter, 37);
      check_val("clear_state_running", running, 0);
      cycles(1);
      check_val("cleared_cnt", counter, 0);

      // div must be zero after clear: first tick four cycles after entry.
      cycles(10);
      pulse_btns(3'b001);
      check_val("post_clr_running", running, 1);
      check_val("post_clr_tick0", tick, 0);
      cycles(3);
      check_val("post_clr_tick3", tick, 0);
      cycles(1);
      check_val("post_clr_tick4", tick, 1);
      cycles(1);
      check_val("post_clr_cnt", counter, 1);

      // Down through 0 -> 9999 -> 9998, then up through 9999 -> 0.
      pulse_btns(3'b100);
      check_val("mode_down_set", mode_down, 1);
      check_val("mode_cnt", counter, 2);
      cycles(8);
      check_val("down_to_0", counter, 0);
      cycles(5);
      check_val("wrap_9999", counter, 9999);
      cycles(5);
      check_val("down_9998", counter, 9998);
      pulse_btns(3'b100);
      check_val("mode_up_set", mode_down, 0);
      check_val("mode_up_cnt", counter, 9997);
      cycles(8);
      check_val("up_9999", counter, 9999);
      cycles(5);
      check_val("wrap_0", counter, 0);

      // Stop coinciding with a tick: step taken, then stopped.
      cycles(3);
      pulse_btns(3'b001);
      check_val("stop_on_tick_running", running, 0);
      check_val("stop_on_tick_cnt", counter, 2);

      // Bounce rejection.
      cycles(10);
      for (int i = 0; i < 10; i++) begin
         btn[0] = ~btn[0];
         cycles(2);
      end
      cycles(10);
      check_val("bounce_running", running, 0);
      check_val("bounce_cnt", counter, 2);
      for (int i = 0; i < 10; i++) begin
         btn[0] = ~btn[0];
         cycles(2);
      end
      btn[0] = 1'b1;
      cycles(10);
      check_val("bounce_hold_running", running, 1);
      btn[0] = 1'b0;
      cycles(10);
      check_val("release_no_toggle", running, 1);

      // Simultaneous run/stop and clear in STOP: clear wins, run pulse dropped.
      pulse_btns(3'b001);
      check_val("stop_again", running, 0);
      cycles(10);
      btn = 3'b011;
      cycles(7);
      check_val("both_clear_running", running, 0);
      cycles(1);
      check_val("both_cnt", counter, 0);
      check_val("both_running", running, 0);
      cycles(5);
      check_val("both_still_stop", running, 0);
      btn = 3'b000;

      // Asynchronous reset mid-run with run/stop held through it.
      cycles(10);
      pulse_btns(3'b100);
      cycles(4);
      pulse_btns(3'b001);
      cycles(12);
      check_val("pre_rst_running", running, 1);
      check_val("pre_rst_mode", mode_down, 1);
      btn[0] = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_counter", counter, 0);
      check_val("async_rst_running", running, 0);
      check_val("async_rst_mode", mode_down, 0);
      check_val("async_rst_tick", tick, 0);
      cycles(2);
      rst = 1'b0;
      cycles(6);
      check_val("held_btn_wait", running, 0);
      cycles(1);
      check_val("held_btn_run", running, 1);
      btn[0] = 1'b0;
      cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
